// File: rtl/sc_sng_if.sv
// ============================================================================
// Module      : sc_sng_if
// Description : Request/stream bundle between a controller and sc_sng.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sc_sng_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic [7:0]       value;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             seed_load;
    logic [7:0]       seed;
    logic             bit_out;
    logic             bit_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, value, len, abort, seed_load, seed,
        input  bit_out, bit_valid, busy, done
    );

    modport slave (
        input  start, value, len, abort, seed_load, seed,
        output bit_out, bit_valid, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/sc_sng.sv
// ============================================================================
// Module      : sc_sng
// Description : LFSR-based stochastic number generator emitting a unipolar
//               bit stream of programmable length with probability value/256.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_sng #(
    parameter int         LEN_W = 16,
    parameter logic [7:0] SEED  = 8'h01
) (
    input  wire logic  clk,
    input  wire logic  reset,
    sc_sng_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_lfsr;
    logic [7:0]       w_lfsr_next;
    logic [7:0]       w_lfsr_src;
    logic [7:0]       w_seed_eff;
    logic [7:0]       r_value;
    logic [7:0]       w_value_next;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_next;
    logic             r_bit_out;
    logic             w_bit_out_next;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    assign w_seed_eff = (bus.seed == 8'h00) ? SEED : bus.seed;

    // Each bit is decided at the edge that opens its cycle and held in
    // r_bit_out, so an abort sampled at an edge suppresses the bit that
    // edge would have produced and leaves the LFSR untouched.
    always_comb begin
        w_state_next   = r_state;
        w_lfsr_next    = r_lfsr;
        w_lfsr_src     = r_lfsr;
        w_value_next   = r_value;
        w_cnt_next     = r_cnt;
        w_bit_out_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.seed_load) begin
                    w_lfsr_src = w_seed_eff;
                end
                w_lfsr_next = w_lfsr_src;
                if (bus.start) begin
                    if (bus.len != '0) begin
                        w_value_next   = bus.value;
                        w_cnt_next     = bus.len;
                        w_bit_out_next = (w_lfsr_src < bus.value);
                        w_lfsr_next    = lfsr_step(w_lfsr_src);
                        w_state_next   = S_RUN;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    w_cnt_next   = '0;
                    w_state_next = S_IDLE;
                end else if (r_cnt == LEN_W'(1)) begin
                    w_cnt_next   = '0;
                    w_state_next = S_DONE;
                end else begin
                    w_cnt_next     = r_cnt - LEN_W'(1);
                    w_bit_out_next = (r_lfsr < r_value);
                    w_lfsr_next    = lfsr_step(r_lfsr);
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr    <= SEED;
            r_value   <= 8'h00;
            r_cnt     <= '0;
            r_bit_out <= 1'b0;
        end else begin
            r_lfsr    <= w_lfsr_next;
            r_value   <= w_value_next;
            r_cnt     <= w_cnt_next;
            r_bit_out <= w_bit_out_next;
        end
    end

    assign bus.bit_valid = (r_state == S_RUN);
    assign bus.bit_out   = r_bit_out;
    assign bus.busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign bus.done      = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: doc/sc_sng.md
SC_SNG -- requirements
Module: sc_sng

Interface
REQ-001 Parameter LEN_W, default 16: width of the stream-length input and of the internal bit counter.
REQ-002 Parameter SEED, default 8'h01: LFSR value after reset and substitute for a zero seed load. SEED SHALL be nonzero.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request one stream; sampled only in IDLE.
REQ-006 value  input  8  unipolar probability numerator (p = value/256); latched at accepted start.
REQ-007 len  input  LEN_W  number of stream bits to emit; latched at accepted start.
REQ-008 abort  input  1  terminate the running stream.
REQ-009 seed_load  input  1  load the LFSR from seed; honoured only in IDLE.
REQ-010 seed  input  8  LFSR load value.
REQ-011 bit_out  output  1  stochastic bit; 0 whenever bit_valid=0.
REQ-012 bit_valid  output  1  bit_out is a stream bit this cycle.
REQ-013 busy  output  1  high in RUN and DONE.
REQ-014 done  output  1  one-cycle pulse at stream completion.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-016 In IDLE, start=1 with len!=0: latch value_q=value and cnt=len; RUN on the next cycle.
REQ-017 In IDLE, start=1 with len=0: DONE on the next cycle; no bit_valid is asserted.
REQ-018 In RUN: bit_valid=1; bit_out=(lfsr < value_q) as an unsigned 8-bit compare; lfsr advances; cnt decrements.
REQ-019 In RUN with cnt=1 and abort=0: that is the last bit; the next state is DONE.
REQ-020 In RUN with abort=1: no bit is emitted that cycle (bit_valid=0); the next state is IDLE; no done pulse; the LFSR holds.
REQ-021 In DONE: done=1 for exactly one cycle; the next state is IDLE unconditionally.
REQ-022 start is ignored in RUN and DONE; abort is ignored outside RUN.
REQ-023 Latency: start sampled at edge t gives the first bit_valid in the cycle after edge t. The stream is exactly len contiguous cycles. done follows the last bit on the next cycle.
REQ-024 LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. Next state = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. Period 255; it never reaches 0.
REQ-025 The LFSR SHALL advance only in cycles where bit_valid=1, and SHALL continue across streams; it is not reseeded at start.
REQ-026 seed_load=1 in IDLE: lfsr=seed, or SEED if seed=0. If seed_load and start are both asserted in the same IDLE cycle, the load applies first, so the first stream bit uses the loaded value.
REQ-027 bit_out, bit_valid, busy and done SHALL decode from registered state only, with no combinational path from any input.
REQ-028 The comparator covers the full range: value=0 always gives 0; value=255 gives 1 for every lfsr except 255.

Reset
REQ-029 reset=1 at any edge, including mid-RUN: state=IDLE, lfsr=SEED, cnt=0, value_q=0.
REQ-030 During reset and in the following IDLE cycle: bit_out=0, bit_valid=0, busy=0, done=0.
REQ-031 A stream interrupted by reset produces no done pulse.

Verification
REQ-032 Load seed=8'h01; start with value=8'h80, len=255 -> 255 consecutive bit_valid cycles; exactly 127 ones; done one cycle after the last bit.
REQ-033 Load seed=8'h01; start with value=8'h00, len=255 -> 0 ones; then start with value=8'hFF, len=255 -> 254 ones, since the LFSR continues with the same 255-state cycle.
REQ-034 Load seed=8'h01; start with value=8'h02, len=2 -> bit sequence 1, 0 (lfsr 01 then 02); done; busy high for 3 cycles.
REQ-035 start with len=0 -> no bit_valid; done high on the cycle after start, then IDLE.
REQ-036 len=10 with abort at the 4th RUN cycle -> exactly 3 valid bits, no done, IDLE the next cycle; the next stream continues from the LFSR state after 3 advances.
REQ-037 reset asserted mid-RUN -> all outputs 0 on the next cycle; lfsr=8'h01; a subsequent len=1, value=8'h02 stream emits 1.
